// File: rtl/rv32i_exec_mem_pkg.sv
// Shared constants for the RV32I execute/memory slice: data width, opcode
// and func3 values, ALU operation codes and the control-output encodings.
// The helper maps an R-type/OP-IMM func3 plus the alternate bit onto an ALU op.
package rv32i_exec_mem_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_ctrl_e;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] WB_MEMORY_READ    = 2'b00;
    localparam logic [1:0] WB_ALU_RESULTS    = 2'b01;
    localparam logic [1:0] WB_PC_PLUS_4      = 2'b10;
    localparam logic [1:0] WB_U_TYPE_SEC_SRC = 2'b11;

    localparam logic [1:0] SA_NONE  = 2'b00;
    localparam logic [1:0] SA_LUI   = 2'b01;
    localparam logic [1:0] SA_AUIPC = 2'b10;
    localparam logic [1:0] SA_JALR  = 2'b11;

    // alt selects SUB for func3=000 and SRA for func3=101.
    function automatic alu_ctrl_e alu_op_decode(input logic [2:0] f3, input logic alt);
        alu_ctrl_e op;
        case (f3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SR:      op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32i_exec_mem_if.sv
// Bus bundle of the execute/memory slice: instruction and operands in,
// RAM init/debug port, control outputs and ALU/RAM results.
// master = CPU/host side, slave = the rv32i_exec_mem block.
interface rv32i_exec_mem_if #(parameter int AW = 10) ();
    logic [31:0]   instr;
    logic [31:0]   rs1;
    logic [31:0]   rs2;
    logic [31:0]   imm;
    logic          init_done;
    logic [AW-1:0] init_w_addr;
    logic [31:0]   init_w_dat;
    logic          init_w_enb;
    logic [AW-1:0] debug_addr;
    logic [31:0]   debug_data;
    logic          branch;
    logic [2:0]    imm_src;
    logic          reg_write;
    logic [1:0]    wrt_back_src;
    logic [1:0]    second_add_src;
    logic          mem_2_reg;
    logic [31:0]   alu_result;
    logic [31:0]   mem_rdata;

    modport master (
        output instr, rs1, rs2, imm, init_done, init_w_addr, init_w_dat, init_w_enb, debug_addr,
        input  debug_data, branch, imm_src, reg_write, wrt_back_src, second_add_src,
               mem_2_reg, alu_result, mem_rdata
    );

    modport slave (
        input  instr, rs1, rs2, imm, init_done, init_w_addr, init_w_dat, init_w_enb, debug_addr,
        output debug_data, branch, imm_src, reg_write, wrt_back_src, second_add_src,
               mem_2_reg, alu_result, mem_rdata
    );
endinterface

// File: rtl/rv32i_exec_mem_alu.sv
// 32-bit RV32I ALU. Inputs: operands a, b and alu_ctrl.
// Outputs: result, zero (result==0), last_bit (result[0]).
module rv32i_exec_mem_alu
    import rv32i_exec_mem_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  alu_ctrl_e             alu_ctrl,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic                  last_bit
);
    logic signed [DATA_WIDTH-1:0] a_s;
    logic signed [DATA_WIDTH-1:0] b_s;
    logic [4:0]                   shamt;

    assign a_s   = a;
    assign b_s   = b;
    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (alu_ctrl)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = a_s >>> shamt;
            ALU_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, a_s < b_s};
            ALU_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, a < b};
            default:  result = '0;
        endcase
    end

    assign zero     = (result == '0);
    assign last_bit = result[0];
endmodule

// File: rtl/rv32i_exec_mem_bram32.sv
// Word-organised data RAM with byte addressing (low 2 address bits ignored).
// One synchronous write port, two combinational read ports (data, debug).
// rst clears every word and overrides a same-cycle write.
module rv32i_exec_mem_bram32 #(
    parameter int DEPTH = 256,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] w_addr,
    input  logic [31:0]   w_data,
    input  logic [AW-1:0] r_addr,
    output logic [31:0]   r_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [31:0]   dbg_data
);
    logic [31:0] mem [DEPTH];
    logic        unused_byte_bits;

    assign unused_byte_bits = ^{w_addr[1:0], r_addr[1:0], dbg_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[w_addr[AW-1:2]] <= w_data;
        end
    end

    assign r_data   = mem[r_addr[AW-1:2]];
    assign dbg_data = mem[dbg_addr[AW-1:2]];
endmodule

// File: rtl/rv32i_exec_mem_control.sv
// Main control decoder plus branch resolution.
// Inputs: rst, instr, ALU flags zero/last_bit. Outputs: all control signals.
// Decode and branch resolution sit in separate processes so the ALU flag
// path (decode -> ALU -> flags -> branch) is not a combinational loop.
module rv32i_exec_mem_control
    import rv32i_exec_mem_pkg::*;
(
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        last_bit,
    output logic        branch,
    output logic [2:0]  imm_src,
    output logic        reg_write,
    output logic [1:0]  wrt_back_src,
    output logic [1:0]  second_add_src,
    output logic        mem_2_reg,
    output logic        mem_read,
    output logic        mem_write,
    output logic        alu_src,
    output alu_ctrl_e   alu_ctrl
);
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       is_branch;
    logic       is_jump;
    logic       unused_instr_bits;

    assign opcode = instr[6:0];
    assign func3  = instr[14:12];
    assign func7  = instr[31:25];
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    always_comb begin
        imm_src        = IMM_I;
        reg_write      = 1'b0;
        wrt_back_src   = WB_MEMORY_READ;
        second_add_src = SA_NONE;
        mem_2_reg      = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        alu_src        = 1'b0;
        alu_ctrl       = ALU_ADD;
        is_branch      = 1'b0;
        is_jump        = 1'b0;
        if (!rst) begin
            case (opcode)
                OP_R: begin
                    reg_write    = 1'b1;
                    wrt_back_src = WB_ALU_RESULTS;
                    alu_ctrl     = alu_op_decode(func3, func7[5]);
                end
                OP_IMM: begin
                    alu_src      = 1'b1;
                    reg_write    = 1'b1;
                    wrt_back_src = WB_ALU_RESULTS;
                    // addi has no subtract form; only shifts use instr[30].
                    alu_ctrl     = alu_op_decode(func3, (func3 == F3_SR) && instr[30]);
                end
                OP_LOAD: begin
                    alu_src   = 1'b1;
                    mem_read  = 1'b1;
                    mem_2_reg = 1'b1;
                    reg_write = 1'b1;
                end
                OP_STORE: begin
                    imm_src   = IMM_S;
                    alu_src   = 1'b1;
                    mem_write = 1'b1;
                end
                OP_BRANCH: begin
                    imm_src        = IMM_B;
                    second_add_src = SA_AUIPC;
                    is_branch      = 1'b1;
                    case (func3)
                        F3_BLT, F3_BGE:   alu_ctrl = ALU_SLT;
                        F3_BLTU, F3_BGEU: alu_ctrl = ALU_SLTU;
                        default:          alu_ctrl = ALU_SUB;
                    endcase
                end
                OP_JAL: begin
                    imm_src        = IMM_J;
                    second_add_src = SA_AUIPC;
                    reg_write      = 1'b1;
                    wrt_back_src   = WB_PC_PLUS_4;
                    is_jump        = 1'b1;
                end
                OP_JALR: begin
                    alu_src        = 1'b1;
                    second_add_src = SA_JALR;
                    reg_write      = 1'b1;
                    wrt_back_src   = WB_PC_PLUS_4;
                    is_jump        = 1'b1;
                end
                OP_LUI: begin
                    imm_src        = IMM_U;
                    second_add_src = SA_LUI;
                    reg_write      = 1'b1;
                    wrt_back_src   = WB_U_TYPE_SEC_SRC;
                end
                OP_AUIPC: begin
                    imm_src        = IMM_U;
                    second_add_src = SA_AUIPC;
                    reg_write      = 1'b1;
                    wrt_back_src   = WB_U_TYPE_SEC_SRC;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        branch = is_jump;
        if (is_branch) begin
            case (func3)
                F3_BEQ:           branch = zero;
                F3_BNE:           branch = !zero;
                F3_BLT, F3_BLTU:  branch = last_bit;
                F3_BGE, F3_BGEU:  branch = !last_bit;
                default:          branch = 1'b0;
            endcase
        end
    end
endmodule

// File: rtl/rv32i_exec_mem.sv
// RV32I single-cycle execute/memory slice: control decoder, ALU and data RAM.
// Ports: clk, rst (sync, active-high) and the slave side of rv32i_exec_mem_if
// (instruction/operands in, init/debug RAM port, control and result outputs).
// The top only muxes the ALU second operand and the RAM write-port source.
module rv32i_exec_mem
    import rv32i_exec_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 10
) (
    input  logic              clk,
    input  logic              rst,
    rv32i_exec_mem_if.slave   bus
);
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    alu_ctrl_e   alu_ctrl;
    logic        zero;
    logic        last_bit;
    logic [31:0] src2;
    logic [31:0] rd_word;
    logic        ram_we;
    logic [AW-1:0] ram_w_addr;
    logic [31:0] ram_w_data;

    rv32i_exec_mem_control u_control (
        .rst            (rst),
        .instr          (bus.instr),
        .zero           (zero),
        .last_bit       (last_bit),
        .branch         (bus.branch),
        .imm_src        (bus.imm_src),
        .reg_write      (bus.reg_write),
        .wrt_back_src   (bus.wrt_back_src),
        .second_add_src (bus.second_add_src),
        .mem_2_reg      (bus.mem_2_reg),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .alu_src        (alu_src),
        .alu_ctrl       (alu_ctrl)
    );

    assign src2 = alu_src ? bus.imm : bus.rs2;

    rv32i_exec_mem_alu u_alu (
        .a        (bus.rs1),
        .b        (src2),
        .alu_ctrl (alu_ctrl),
        .result   (bus.alu_result),
        .zero     (zero),
        .last_bit (last_bit)
    );

    // Until init_done the host owns the write port; afterwards stores do.
    always_comb begin
        ram_we     = bus.init_w_enb;
        ram_w_addr = bus.init_w_addr;
        ram_w_data = bus.init_w_dat;
        if (bus.init_done) begin
            ram_we     = mem_write;
            ram_w_addr = bus.alu_result[AW-1:0];
            ram_w_data = bus.rs2;
        end
    end

    rv32i_exec_mem_bram32 #(.DEPTH(DEPTH), .AW(AW)) u_bram (
        .clk      (clk),
        .rst      (rst),
        .we       (ram_we),
        .w_addr   (ram_w_addr),
        .w_data   (ram_w_data),
        .r_addr   (bus.alu_result[AW-1:0]),
        .r_data   (rd_word),
        .dbg_addr (bus.debug_addr),
        .dbg_data (bus.debug_data)
    );

    assign bus.mem_rdata = mem_read ? rd_word : '0;
endmodule

// File: tb/tb_rv32i_exec_mem.sv
// Self-checking bench for rv32i_exec_mem: hand-written sequences for reset,
// RAM init, stores and reset-clear, plus a table of directed decode/ALU vectors.
module tb_rv32i_exec_mem;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rv32i_exec_mem_if #(.AW(10)) bus ();

    rv32i_exec_mem #(.DEPTH(256), .AW(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        br;
        logic [2:0]  isrc;
        logic        rw;
        logic [1:0]  wbs;
        logic [1:0]  sas;
        logic        m2r;
        logic        chk_alu;
        logic [31:0] alu;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] I_NOP  = 32'h00000013;
    localparam logic [31:0] I_SW   = 32'h0020A423;
    localparam logic [31:0] I_LW   = 32'h0000A003;

    function automatic vec_t mk(input string name, input logic [31:0] instr, rs1, rs2, imm,
                                input logic br, input logic [2:0] isrc, input logic rw,
                                input logic [1:0] wbs, sas, input logic m2r,
                                input logic chk_alu, input logic [31:0] alu, rdata);
        vec_t v;
        v.name = name; v.instr = instr; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.br = br; v.isrc = isrc; v.rw = rw; v.wbs = wbs; v.sas = sas; v.m2r = m2r;
        v.chk_alu = chk_alu; v.alu = alu; v.rdata = rdata;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_ctrl_zero(input string tag);
        chk({tag, " branch"},         32'(bus.branch), 32'h0);
        chk({tag, " imm_src"},        32'(bus.imm_src), 32'h0);
        chk({tag, " reg_write"},      32'(bus.reg_write), 32'h0);
        chk({tag, " wrt_back_src"},   32'(bus.wrt_back_src), 32'h0);
        chk({tag, " second_add_src"}, 32'(bus.second_add_src), 32'h0);
        chk({tag, " mem_2_reg"},      32'(bus.mem_2_reg), 32'h0);
        chk({tag, " mem_rdata"},      bus.mem_rdata, 32'h0);
    endtask

    task automatic set_ops(input logic [31:0] instr, rs1, rs2, imm);
        bus.instr = instr; bus.rs1 = rs1; bus.rs2 = rs2; bus.imm = imm;
    endtask

    task automatic peek(input logic [9:0] addr, input logic [31:0] exp, input string nm);
        bus.debug_addr = addr;
        #1;
        chk(nm, bus.debug_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.init_done = 1'b0;
        bus.init_w_addr = '0;
        bus.init_w_dat = '0;
        bus.init_w_enb = 1'b0;
        bus.debug_addr = '0;
        set_ops(I_LW, 32'h0, 32'h0, 32'h8);

        // Reset: controls forced low even with a valid load opcode.
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk_ctrl_zero("reset");
        peek(10'h000, 32'h0, "reset ram[0]");

        @(negedge clk);
        rst = 1'b0;
        set_ops(I_NOP, 32'h0, 32'h0, 32'h0);

        // Init port writes 1, 2, 3 at bytes 0, 4, 8.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.init_w_addr = 10'(i * 4);
            bus.init_w_dat  = 32'(i + 1);
            bus.init_w_enb  = 1'b1;
        end
        @(negedge clk);
        bus.init_w_enb = 1'b0;
        peek(10'h000, 32'h1, "init ram[0]");
        peek(10'h004, 32'h2, "init ram[4]");
        peek(10'h008, 32'h3, "init ram[8]");

        // Store while init_done=0 must not reach the RAM.
        set_ops(I_SW, 32'h4, 32'hDEAD, 32'h8);
        @(posedge clk);
        @(negedge clk);
        peek(10'h00C, 32'h0, "store blocked before init_done");

        // sw rs1=4 rs2=8 imm=8 -> byte 0xC; old word visible until the edge.
        bus.init_done = 1'b1;
        set_ops(I_SW, 32'h4, 32'h8, 32'h8);
        peek(10'h00C, 32'h0, "sw before edge");
        chk("sw reg_write", 32'(bus.reg_write), 32'h0);
        chk("sw imm_src", 32'(bus.imm_src), 32'h1);
        chk("sw alu_result", bus.alu_result, 32'hC);
        chk("sw mem_rdata", bus.mem_rdata, 32'h0);
        @(posedge clk); #1;
        chk("sw after edge", bus.debug_data, 32'h8);
        @(negedge clk);
        set_ops(I_NOP, 32'h0, 32'h0, 32'h0);

        //          name        instr         rs1           rs2           imm          br isrc  rw wbs    sas    m2r ca alu           rdata
        vecs.push_back(mk("lw 8",   I_LW,         32'h0,        32'h0,        32'h8,        0, 3'd0, 1, 2'b00, 2'b00, 1, 1, 32'h8,        32'h3));
        vecs.push_back(mk("lw C",   I_LW,         32'h4,        32'h0,        32'h8,        0, 3'd0, 1, 2'b00, 2'b00, 1, 1, 32'hC,        32'h8));
        vecs.push_back(mk("jalr",   32'h000080E7, 32'h100,      32'h0,        32'h4,        1, 3'd0, 1, 2'b10, 2'b11, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk("jal",    32'h0000006F, 32'h0,        32'h0,        32'h0,        1, 3'd4, 1, 2'b10, 2'b10, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk("beq",    32'h00000063, 32'h5,        32'h5,        32'h0,        1, 3'd2, 0, 2'b00, 2'b10, 0, 1, 32'h0,        32'h0));
        vecs.push_back(mk("bne",    32'h00001063, 32'h5,        32'h5,        32'h0,        0, 3'd2, 0, 2'b00, 2'b10, 0, 1, 32'h0,        32'h0));
        vecs.push_back(mk("blt",    32'h00004063, 32'hFFFFFFFF, 32'h1,        32'h0,        1, 3'd2, 0, 2'b00, 2'b10, 0, 1, 32'h1,        32'h0));
        vecs.push_back(mk("bge",    32'h00005063, 32'hFFFFFFFF, 32'h1,        32'h0,        0, 3'd2, 0, 2'b00, 2'b10, 0, 1, 32'h1,        32'h0));
        vecs.push_back(mk("bltu",   32'h00006063, 32'hFFFFFFFF, 32'h1,        32'h0,        0, 3'd2, 0, 2'b00, 2'b10, 0, 1, 32'h0,        32'h0));
        vecs.push_back(mk("bgeu",   32'h00007063, 32'hFFFFFFFF, 32'h1,        32'h0,        1, 3'd2, 0, 2'b00, 2'b10, 0, 1, 32'h0,        32'h0));
        vecs.push_back(mk("sra",    32'h40005033, 32'hFFFFFFF0, 32'h4,        32'h0,        0, 3'd0, 1, 2'b01, 2'b00, 0, 1, 32'hFFFFFFFF, 32'h0));
        vecs.push_back(mk("sub",    32'h40000033, 32'h3,        32'h3,        32'h0,        0, 3'd0, 1, 2'b01, 2'b00, 0, 1, 32'h0,        32'h0));
        vecs.push_back(mk("add wrap", 32'h00000033, 32'h7,      32'hFFFFFFFF, 32'h0,        0, 3'd0, 1, 2'b01, 2'b00, 0, 1, 32'h6,        32'h0));
        vecs.push_back(mk("xor",    32'h00004033, 32'h0000F0F0, 32'h0000FF00, 32'h0,        0, 3'd0, 1, 2'b01, 2'b00, 0, 1, 32'h00000FF0, 32'h0));
        vecs.push_back(mk("srli",   32'h00005013, 32'h80000000, 32'h0,        32'h1F,       0, 3'd0, 1, 2'b01, 2'b00, 0, 1, 32'h1,        32'h0));
        vecs.push_back(mk("srai",   32'h40005013, 32'h80000000, 32'h0,        32'h41F,      0, 3'd0, 1, 2'b01, 2'b00, 0, 1, 32'hFFFFFFFF, 32'h0));
        vecs.push_back(mk("slli",   32'h00001013, 32'h1,        32'h0,        32'h1F,       0, 3'd0, 1, 2'b01, 2'b00, 0, 1, 32'h80000000, 32'h0));
        vecs.push_back(mk("sltiu",  32'h00003013, 32'h1,        32'h0,        32'hFFFFFFFF, 0, 3'd0, 1, 2'b01, 2'b00, 0, 1, 32'h1,        32'h0));
        vecs.push_back(mk("lui",    32'h00000037, 32'h0,        32'h0,        32'h0,        0, 3'd3, 1, 2'b11, 2'b01, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk("auipc",  32'h00000017, 32'h0,        32'h0,        32'h0,        0, 3'd3, 1, 2'b11, 2'b10, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk("unknown", 32'h0000007F, 32'h0,       32'h0,        32'h0,        0, 3'd0, 0, 2'b00, 2'b00, 0, 0, 32'h0,        32'h0));

        foreach (vecs[i]) begin
            @(negedge clk);
            set_ops(vecs[i].instr, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            #1;
            chk({vecs[i].name, " branch"},         32'(bus.branch), 32'(vecs[i].br));
            chk({vecs[i].name, " imm_src"},        32'(bus.imm_src), 32'(vecs[i].isrc));
            chk({vecs[i].name, " reg_write"},      32'(bus.reg_write), 32'(vecs[i].rw));
            chk({vecs[i].name, " wrt_back_src"},   32'(bus.wrt_back_src), 32'(vecs[i].wbs));
            chk({vecs[i].name, " second_add_src"}, 32'(bus.second_add_src), 32'(vecs[i].sas));
            chk({vecs[i].name, " mem_2_reg"},      32'(bus.mem_2_reg), 32'(vecs[i].m2r));
            chk({vecs[i].name, " mem_rdata"},      bus.mem_rdata, vecs[i].rdata);
            if (vecs[i].chk_alu) begin
                chk({vecs[i].name, " alu_result"}, bus.alu_result, vecs[i].alu);
            end
        end

        // rst with a store pending: controls low, whole RAM cleared, write dropped.
        @(negedge clk);
        rst = 1'b1;
        set_ops(I_SW, 32'h10, 32'h55, 32'h0);
        #1;
        chk_ctrl_zero("rst store");
        @(posedge clk); #1;
        peek(10'h000, 32'h0, "rst clr ram[0]");
        peek(10'h004, 32'h0, "rst clr ram[4]");
        peek(10'h008, 32'h0, "rst clr ram[8]");
        peek(10'h00C, 32'h0, "rst clr ram[C]");
        peek(10'h010, 32'h0, "rst blocks write ram[10]");
        @(negedge clk);
        rst = 1'b0;
        set_ops(I_LW, 32'h0, 32'h0, 32'h8);
        #1;
        chk("lw after reset mem_rdata", bus.mem_rdata, 32'h0);
        chk("lw after reset reg_write", 32'(bus.reg_write), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
